// File: rtl/mdu_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage; operands are captured at issue.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate operations (ops 7-10).
module mdu_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd5;
   localparam logic [3:0] OP_DIVU  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CNT_W-1:0]        cnt_p0;
   logic signed [WIDTH-1:0] a_p0;
   logic signed [WIDTH-1:0] b_p0;
   logic [3:0]              op_p0;

   logic                    accept;
   logic                    is_mul;
   logic                    is_div;
   logic                    sgn;
   logic [2*WIDTH-1:0]      prod;
   logic [2*WIDTH-1:0]      res;

   function automatic logic mul_class(input logic [3:0] o);
`ifdef MDU_MADD_EN
      return (o == OP_MULT) || (o == OP_MULTU) || ((o >= OP_MADD) && (o <= OP_MSUBU));
`else
      return (o == OP_MULT) || (o == OP_MULTU);
`endif
   endfunction

   // Low 2W bits of the product of the extended operands equal the signed or unsigned product.
   function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             s);
      logic [2*WIDTH-1:0] xe;
      logic [2*WIDTH-1:0] ye;
      xe = s ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
      ye = s ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
      return xe * ye;
   endfunction

   // Returns {remainder, quotient}; zero divisor and signed overflow are pinned to fixed results.
   function automatic logic [2*WIDTH-1:0] div_full(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y,
                                                  input logic                    s);
      logic signed [WIDTH-1:0] q;
      logic signed [WIDTH-1:0] r;
      logic [WIDTH-1:0]        ux;
      logic [WIDTH-1:0]        uy;
      ux = x;
      uy = y;
      if (uy == '0) begin
         q = '1;
         r = x;
      end else if (s && (ux == MOST_NEG) && (uy == '1)) begin
         q = MOST_NEG;
         r = '0;
      end else if (s) begin
         q = x / y;
         r = x % y;
      end else begin
         q = ux / uy;
         r = ux % uy;
      end
      return {r, q};
   endfunction

   always_comb begin
      is_mul = mul_class(op);
      is_div = (op == OP_DIV) || (op == OP_DIVU);
      // The commit cycle counts as free so a new operation can start on the commit edge.
      accept = start & ~flush & (cnt_p0 <= CNT_W'(1));
   end

   always_comb begin
      sgn  = (op_p0 == OP_MULT) || (op_p0 == OP_DIV) ||
             (op_p0 == OP_MADD) || (op_p0 == OP_MSUB);
      prod = mul_full(a_p0, b_p0, sgn);
      res  = prod;
      if ((op_p0 == OP_DIV) || (op_p0 == OP_DIVU))
         res = div_full(a_p0, b_p0, sgn);
`ifdef MDU_MADD_EN
      else if ((op_p0 == OP_MADD) || (op_p0 == OP_MADDU))
         res = {hi, lo} + prod;
      else if ((op_p0 == OP_MSUB) || (op_p0 == OP_MSUBU))
         res = {hi, lo} - prod;
`endif
   end

   assign busy = (cnt_p0 != '0);

   // Stage p0: issue capture, countdown, commit into HI/LO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_p0 <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
         op_p0  <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (cnt_p0 != '0)
            cnt_p0 <= cnt_p0 - CNT_W'(1);
         if (cnt_p0 == CNT_W'(1))
            {hi, lo} <= res;
         if (accept) begin
            if (op == OP_MTHI)
               hi <= a;
            if (op == OP_MTLO)
               lo <= a;
            if (is_mul || is_div) begin
               a_p0   <= a;
               b_p0   <= b;
               op_p0  <= op;
               cnt_p0 <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomised self-checking bench for mdu_unit against a plain-arithmetic HI/LO reference model.
module tb_mdu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int passed = 0;
   int total  = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic bit op_valid(input logic [3:0] o);
`ifdef MDU_MADD_EN
      return (o >= 4'd1) && (o <= 4'd10);
`else
      return (o >= 4'd1) && (o <= 4'd6);
`endif
   endfunction

   function automatic int model_lat(input logic [3:0] o);
      if (!op_valid(o)) return 0;
      if (o == 4'd3 || o == 4'd4) return 0;
      if (o == 4'd5 || o == 4'd6) return 10;
      return 5;
   endfunction

   function void model_exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      p;
      int          sx, sy;
      logic [63:0] acc;
      sx = signed'(x);
      sy = signed'(y);
      if (!op_valid(o)) return;
      case (o)
         4'd1, 4'd7, 4'd9: p = longint'(sx) * longint'(sy);
         default:          p = longint'({32'b0, x}) * longint'({32'b0, y});
      endcase
      acc = {m_hi, m_lo};
      case (o)
         4'd1, 4'd2: acc = p;
         4'd3: acc[63:32] = x;
         4'd4: acc[31:0] = x;
         4'd5: begin
            if (y == 0) acc = {x, 32'hFFFFFFFF};
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) acc = {32'h0, 32'h80000000};
            else acc = {32'(sx % sy), 32'(sx / sy)};
         end
         4'd6: begin
            if (y == 0) acc = {x, 32'hFFFFFFFF};
            else acc = {x % y, x / y};
         end
         4'd7, 4'd8: acc = acc + p;
         default: acc = acc - p;
      endcase
      {m_hi, m_lo} = acc;
   endfunction

   // Issues one op, scrambles a/b after the issue edge and counts busy cycles (bounded).
   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = '0; flush = 1'b0; a = '0; b = '0;
      #1;
      total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo got %h_%h exp 0_0", hi, lo); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int n;
      logic [3:0] o;
      logic [31:0] x, y;
      do_op(4'd1, 32'hFFFFFFFE, 32'd3, n); model_exec(4'd1, 32'hFFFFFFFE, 32'd3);
      total++; if (n != 5) $display("FAIL mult_busy got %0d exp 5", n); else passed++;
      total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) $display("FAIL mult_dir got %h_%h exp ffffffff_fffffffa", hi, lo); else passed++;
      do_op(4'd2, 32'hFFFFFFFE, 32'd3, n); model_exec(4'd2, 32'hFFFFFFFE, 32'd3);
      total++; if (hi !== 32'h2 || lo !== 32'hFFFFFFFA) $display("FAIL multu_dir got %h_%h exp 00000002_fffffffa", hi, lo); else passed++;
      for (int i = 0; i < 10; i++) begin
         o = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2;
         x = $urandom; y = $urandom;
         do_op(o, x, y, n); model_exec(o, x, y);
         total++; if (n != 5 || hi !== m_hi || lo !== m_lo)
            $display("FAIL mult_rand op=%0d a=%h b=%h got n=%0d %h_%h exp n=5 %h_%h", o, x, y, n, hi, lo, m_hi, m_lo);
         else passed++;
      end
   endtask

   task automatic test_div;
      int n;
      logic [3:0] o;
      logic [31:0] x, y;
      do_op(4'd5, 32'hFFFFFFF9, 32'd2, n); model_exec(4'd5, 32'hFFFFFFF9, 32'd2);
      total++; if (n != 10) $display("FAIL div_busy got %0d exp 10", n); else passed++;
      total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) $display("FAIL div_neg got %h_%h exp ffffffff_fffffffd", hi, lo); else passed++;
      do_op(4'd6, 32'd7, 32'd0, n); model_exec(4'd6, 32'd7, 32'd0);
      total++; if (hi !== 32'd7 || lo !== 32'hFFFFFFFF) $display("FAIL divu_zero got %h_%h exp 00000007_ffffffff", hi, lo); else passed++;
      do_op(4'd5, 32'h80000000, 32'hFFFFFFFF, n); model_exec(4'd5, 32'h80000000, 32'hFFFFFFFF);
      total++; if (hi !== 32'h0 || lo !== 32'h80000000) $display("FAIL div_ovf got %h_%h exp 00000000_80000000", hi, lo); else passed++;
      for (int i = 0; i < 12; i++) begin
         o = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd6;
         x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 3))
            0: y = 32'h0;
            1: y = 32'($urandom_range(1, 17)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFFFFFF);
            default: y = $urandom;
         endcase
         do_op(o, x, y, n); model_exec(o, x, y);
         total++; if (n != 10 || hi !== m_hi || lo !== m_lo)
            $display("FAIL div_rand op=%0d a=%h b=%h got n=%0d %h_%h exp n=10 %h_%h", o, x, y, n, hi, lo, m_hi, m_lo);
         else passed++;
      end
   endtask

   task automatic test_busy_ignore;
      int n;
      @(negedge clk);
      start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 4'd3; a = 32'h1234;
      @(negedge clk);
      start = 1'b0; a = 32'hDEADBEEF; b = 32'h7;
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      model_exec(4'd1, 32'd3, 32'd5);
      total++; if (n != 3) $display("FAIL ignore_busy_tail got %0d exp 3", n); else passed++;
      total++; if (hi !== 32'h0 || lo !== 32'd15) $display("FAIL ignore_result got %h_%h exp 00000000_0000000f", hi, lo); else passed++;
   endtask

   task automatic test_flush;
      int n;
      @(negedge clk);
      start = 1'b1; op = 4'd1; flush = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy); else passed++;
      total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL flush_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); else passed++;
      do_op(4'd4, 32'h55, 32'h0, n); model_exec(4'd4, 32'h55, 32'h0);
      total++; if (n != 0 || lo !== 32'h55 || hi !== m_hi) $display("FAIL mtlo got n=%0d %h_%h exp n=0 %h_00000055", n, hi, lo, m_hi); else passed++;
      do_op(4'd3, 32'hA5A5_0001, 32'h0, n); model_exec(4'd3, 32'hA5A5_0001, 32'h0);
      total++; if (n != 0 || hi !== 32'hA5A5_0001 || lo !== m_lo) $display("FAIL mthi got n=%0d %h_%h exp n=0 a5a50001_%h", n, hi, lo, m_lo); else passed++;
   endtask

   task automatic test_back_to_back;
      int n;
      logic [31:0] x, y, dx, dy;
      x = $urandom; y = $urandom; dx = $urandom; dy = $urandom_range(1, 1000);
      @(negedge clk);
      start = 1'b1; op = 4'd1; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL b2b_pre_busy got %b exp 1", busy); else passed++;
      @(negedge clk);
      start = 1'b1; op = 4'd6; a = dx; b = dy;
      @(negedge clk);
      start = 1'b0;
      model_exec(4'd1, x, y);
      total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_mult got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); else passed++;
      n = 0;
      while (busy && n < 100) begin n++; @(negedge clk); end
      model_exec(4'd6, dx, dy);
      total++; if (n != 10) $display("FAIL b2b_busy got %0d exp 10", n); else passed++;
      total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL b2b_divu got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); else passed++;
   endtask

   task automatic test_async_reset;
      int n;
      logic [31:0] x, y;
      do_op(4'd4, 32'hCAFE, 32'h0, n); model_exec(4'd4, 32'hCAFE, 32'h0);
      @(negedge clk);
      start = 1'b1; op = 4'd5; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL areset_hilo got %h_%h exp 0_0", hi, lo); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL areset_busy got %b exp 0", busy); else passed++;
      #1 reset = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (12) @(negedge clk);
      total++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) $display("FAIL areset_discard got %h_%h busy=%b exp 0_0 busy=0", hi, lo, busy); else passed++;
      x = $urandom; y = $urandom_range(1, 50);
      do_op(4'd5, x, y, n); model_exec(4'd5, x, y);
      total++; if (n != 10 || hi !== m_hi || lo !== m_lo) $display("FAIL areset_after got n=%0d %h_%h exp n=10 %h_%h", n, hi, lo, m_hi, m_lo); else passed++;
   endtask

   task automatic test_accumulate;
      int n;
      logic [3:0] o;
      logic [31:0] x, y;
`ifdef MDU_MADD_EN
      reset = 1'b1; #1 reset = 1'b0; m_hi = '0; m_lo = '0;
      do_op(4'd4, 32'hFFFFFFFF, 32'h0, n); model_exec(4'd4, 32'hFFFFFFFF, 32'h0);
      do_op(4'd8, 32'd1, 32'd1, n); model_exec(4'd8, 32'd1, 32'd1);
      total++; if (n != 5 || hi !== 32'h1 || lo !== 32'h0) $display("FAIL maddu_carry got n=%0d %h_%h exp n=5 00000001_00000000", n, hi, lo); else passed++;
      for (int i = 0; i < 10; i++) begin
         o = 4'($urandom_range(7, 10));
         x = $urandom; y = $urandom;
         do_op(o, x, y, n); model_exec(o, x, y);
         total++; if (n != 5 || hi !== m_hi || lo !== m_lo)
            $display("FAIL acc_rand op=%0d a=%h b=%h got n=%0d %h_%h exp n=5 %h_%h", o, x, y, n, hi, lo, m_hi, m_lo);
         else passed++;
      end
`else
      for (int i = 7; i <= 10; i++) begin
         o = 4'(i); x = $urandom; y = $urandom;
         do_op(o, x, y, n); model_exec(o, x, y);
         total++; if (n != 0 || hi !== m_hi || lo !== m_lo)
            $display("FAIL acc_disabled op=%0d got n=%0d %h_%h exp n=0 %h_%h", o, n, hi, lo, m_hi, m_lo);
         else passed++;
      end
`endif
   endtask

   task automatic test_invalid_ops;
      int n;
      logic [3:0] o;
      logic [3:0] bad [6] = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      for (int i = 0; i < 6; i++) begin
         o = bad[i];
         do_op(o, $urandom, $urandom, n);
         total++; if (n != model_lat(o) || hi !== m_hi || lo !== m_lo)
            $display("FAIL invalid_op op=%0d got n=%0d %h_%h exp n=0 %h_%h", o, n, hi, lo, m_hi, m_lo);
         else passed++;
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_busy_ignore;
      test_flush;
      test_back_to_back;
      test_invalid_ops;
      test_async_reset;
      test_accumulate;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
